// File: rtl/prog_clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Helpers work on 32-bit values; callers cast to their own CNT_W (CNT_W <= 32).
package prog_clkdiv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned DIV_MIN = 2;

    // Divisors below DIV_MIN cannot form a period with both a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
    endfunction

    function automatic logic [31:0] half_period(input logic [31:0] d);
        return (d >> 1) + {31'b0, d[0]};
    endfunction

endpackage

// File: rtl/clkdiv_shadow_reg.sv
// Shadow/pending/acknowledge register for the active divisor.
// The top raises apply at each point where a new divisor may safely take effect.
module clkdiv_shadow_reg
    import prog_clkdiv_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             apply,
    output logic [CNT_W-1:0] div_active,
    output logic [CNT_W-1:0] div_next,
    output logic             ack
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] shadow;
    logic             pending;
    logic             take;

    assign take     = apply & pending;
    assign div_next = take ? shadow : div_active;

    // A load coinciding with an apply keeps the new value pending for the next window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_active <= DIV_RST;
            shadow     <= DIV_RST;
            pending    <= 1'b0;
            ack        <= 1'b0;
        end else begin
            ack <= take;
            if (take) begin
                div_active <= shadow;
            end
            if (load) begin
                shadow  <= CNT_W'(clamp_div(32'(div_in)));
                pending <= 1'b1;
            end else if (take) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider with glitch-free divisor reload.
// Optional macro PROG_CLKDIV_PHASE_SYNC_EN adds a Sync input that restarts the period.
module prog_clock_divider
    import prog_clkdiv_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
`ifdef PROG_CLKDIV_PHASE_SYNC_EN
    input  logic             Sync,
`endif
    input  logic [CNT_W-1:0] Div_In,
    input  logic             Div_Load,
    output logic             Div_Ack,
    output logic             Clk_Out,
    output logic             Tick,
    output logic [CNT_W-1:0] Count,
    output logic [CNT_W-1:0] Div_Active,
    output state_t           Dbg_State
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] div_next;
    logic             clk_out_next;
    logic             tick_next;
    logic             wrap;
    logic             apply;
    logic             sync_hit;

`ifdef PROG_CLKDIV_PHASE_SYNC_EN
    assign sync_hit = Sync;
`else
    assign sync_hit = 1'b0;
`endif

    assign wrap      = (state == RUN) && (Count == Div_Active - CNT_W'(1));
    assign apply     = (state == IDLE) || wrap;
    assign Dbg_State = state;

    clkdiv_shadow_reg #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_shadow (
        .clk        (Clk),
        .rst        (Rst),
        .load       (Div_Load),
        .div_in     (Div_In),
        .apply      (apply),
        .div_active (Div_Active),
        .div_next   (div_next),
        .ack        (Div_Ack)
    );

    always_comb begin
        state_next   = state;
        count_next   = '0;
        clk_out_next = 1'b0;
        tick_next    = 1'b0;
        case (state)
            IDLE: begin
                if (En) state_next = RUN;
            end
            RUN: begin
                if (!En) begin
                    state_next = IDLE;
                end else if (!(wrap || sync_hit)) begin
                    count_next = Count + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Outputs are derived from next-cycle count and divisor so they stay aligned with Count.
        if (state_next == RUN) begin
            clk_out_next = count_next < CNT_W'(half_period(32'(div_next)));
            tick_next    = count_next == div_next - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            Count   <= '0;
            Clk_Out <= 1'b0;
            Tick    <= 1'b0;
        end else begin
            state   <= state_next;
            Count   <= count_next;
            Clk_Out <= clk_out_next;
            Tick    <= tick_next;
        end
    end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Runtime-programmable clock divider; parametrised successor of the fixed power-of-two ripple divider.
- Divides Clk by any integer 2..2^CNT_W-1.
- Produces a near-50%-duty divided clock (Clk_Out) plus a one-cycle clock-enable pulse (Tick) for downstream logic in the Clk domain.
- New divisors load through a shadow register with an acknowledge, so the output never glitches.

Parameters:
CNT_W, 16, width of divisor and period counter
DIV_DEFAULT, 4, divisor after reset; must be >= 2 and < 2^CNT_W

Ports:
Clk  input  1  system clock, all logic on posedge
Rst  input  1  reset; asynchronous, active-high
En  input  1  run enable; low forces idle
Div_In  input  CNT_W  new divisor value
Div_Load  input  1  one-cycle strobe; captures Div_In into the shadow register
Div_Ack  output  1  one-cycle pulse when the shadow value becomes the active divisor
Clk_Out  output  1  divided clock, registered
Tick  output  1  one-cycle pulse in the last cycle of each output period
Count  output  CNT_W  current period counter
Div_Active  output  CNT_W  divisor currently in use

Behaviour:
- Rst high (async) resets everything:
  - Count=0, Clk_Out=0, Tick=0, Div_Ack=0.
  - Div_Active=DIV_DEFAULT, pending flag cleared, state IDLE.
- State machine, 2 states:
  - IDLE: Count=0, Clk_Out=0, Tick=0. A posedge with En=1 moves to RUN.
  - RUN: a posedge with En=0 moves to IDLE. Count, Clk_Out and Tick are 0 from the following cycle.
- RUN counting:
  - Count steps 0,1,..,D-1,0,... where D=Div_Active.
  - First RUN cycle shows Count=0.
- Clk_Out is 1 in every RUN cycle with Count < ceil(D/2); otherwise 0.
  - All outputs are registered. Compute from the next-state count so Clk_Out is aligned with Count and has no combinational path.
  - Even D gives exact 50% duty. Odd D is high one cycle longer than low (D=3: high, high, low).
- Tick=1 exactly in RUN cycles with Count==D-1; otherwise 0.
- Divisor loading:
  - Div_Load=1 at a posedge: shadow <= clamp(Div_In), pending <= 1.
  - clamp: values 0 or 1 become 2.
  - Multiple loads before application: the last load wins; only one Div_Ack is issued.
  - In RUN, the pending value is applied on the wrap posedge (Count D-1 -> 0). The new period starts at Count=0 with the new D.
  - In IDLE, the pending value is applied on the next posedge.
  - Div_Ack is high in the cycle after application (the cycle where Div_Active first shows the new value).
  - Load in the same cycle as a wrap: the old pending value (if any) is applied now. The new value stays pending until the next wrap.
  - Load with Div_In equal to Div_Active is still treated as a load and still acknowledged.
- En deasserted with a load pending: the value is applied in IDLE as above.
- Reset mid-period discards pending loads and returns to DIV_DEFAULT.
- Counter never exceeds D-1. Arithmetic is unsigned CNT_W bits; there is no overflow path.

Optional Feature:
PROG_CLKDIV_PHASE_SYNC_EN
- Defined: adds input port Sync (1 bit). Sync=1 at a posedge in RUN forces Count=0 next cycle (Clk_Out=1, Tick=0) and restarts the period.
  - Aligns several dividers.
  - Sync coinciding with a wrap also applies any pending divisor.
  - Sync has no effect in IDLE.
- Undefined: no Sync port; the period restarts only via En or Rst.

Decomposition:
- Shared package prog_clkdiv_pkg:
  - state enum (IDLE, RUN)
  - DIV_MIN constant (=2)
  - clamp function
  - half-period function ceil(D/2)
- Sub-module: clkdiv_shadow_reg holds the shadow, pending and ack logic. The counter/FSM stays in the top.

Test Plan:
- Reset, En=1, default D=4 -> Count 0,1,2,3,0; Clk_Out 1,1,0,0; Tick high only at Count=3; 8-cycle check.
- Div_Load Div_In=3 at Count=1 -> Div_Active stays 4 until wrap; Div_Ack one cycle at the first Count=0; then Clk_Out pattern 1,1,0 with period 3.
- Div_Load Div_In=0 then Div_Load Div_In=1 back-to-back -> single Div_Ack, Div_Active=2, Clk_Out toggles every cycle, Tick every second cycle.
- Two loads (6, then 8) within one period -> only 8 is applied at the wrap; exactly one Div_Ack.
- En dropped at Count=2 -> next cycle Count=0, Clk_Out=0, Tick=0. Re-enable -> Count=0, Clk_Out=1 on the first RUN cycle.
- Async Rst pulse mid-period, between edges, with a load pending -> outputs 0 immediately, Div_Active=DIV_DEFAULT, no Div_Ack afterwards. (With PROG_CLKDIV_PHASE_SYNC_EN: Sync at Count=2, D=5 -> Count=0 next cycle.)
